prog_loader: RTL and testbench

- Upstream programming stage for cpu_top.
- Receives a byte stream (valid/ready) carrying a length header and big-endian 32-bit words.
- Writes the words into CPU memory through the cpu_top programming port (mem_en, read_write, address, data_in).
- After the last word it issues the CPU start sequence (cpu_en high, reset pulse), replacing the manual load-then-run stimulus.

---
 rtl/prog_loader.sv | 159 +++++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: upstream programming stage for cpu_top.
// Takes a valid/ready byte stream carrying a 12-bit length header (2 bytes,
// upper nibble of the first byte ignored) followed by big-endian 32-bit words.
// It writes each word into CPU memory via the programming port, then runs the
// CPU start sequence (cpu_en high, cpu_reset pulse of RST_CYCLES cycles).
// Ports:
//   main_clk, reset          clock, async active-high reset
//   start                    one-cycle load request (honoured in IDLE/RUN only)
//   byte_in/valid/ready      input byte stream handshake
//   clr_mem                  one-cycle memory clear pulse (CLEAR_FIRST=1)
//   mem_en/read_write/address/data_in   cpu_top programming port
//   cpu_en, cpu_reset        CPU run control
//   busy, done, err          status (done = pulse on RUN entry, err sticky)
module prog_loader #(
    parameter logic [11:0] BASE_ADDR   = 12'h000,
    parameter int          RST_CYCLES  = 1,
    parameter bit          CLEAR_FIRST = 1'b1
) (
    input  logic        main_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        clr_mem,
    output logic        mem_en,
    output logic        read_write,
    output logic [11:0] address,
    output logic [31:0] data_in,
    output logic        cpu_en,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_HDR_HI, S_HDR_LO, S_COLLECT, S_WRITE, S_START, S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [1:0]  idx_q, idx_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic        err_d, clr_mem_d, mem_en_d, cpu_en_d, cpu_reset_d, busy_d, done_d;
    logic [11:0] address_d;
    logic [31:0] data_in_d;
    logic        xfer;

    // Ready depends on state only so upstream can never create a comb loop.
    assign byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                        (state_q == S_COLLECT);
    assign xfer = byte_valid & byte_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        word_d  = word_q;
        rcnt_d  = rcnt_q;
        err_d   = err;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = CLEAR_FIRST ? S_CLEAR : S_HDR_HI;
                end
            end
            S_CLEAR: state_d = S_HDR_HI;
            S_HDR_HI: begin
                if (xfer) begin
                    count_d = {byte_in[3:0], count_q[7:0]};
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d = {count_q[11:8], byte_in};
                    if ({count_q[11:8], byte_in} == 12'h000) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = 2'd0;
                        addr_d  = BASE_ADDR;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (xfer) begin
                    word_d = {word_q[23:0], byte_in};
                    idx_d  = idx_q + 2'd1;   // wraps to 0 after the 4th byte
                    if (idx_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_q - 12'd1;
                addr_d  = addr_q + 12'd1;
                rcnt_d  = 16'd0;
                state_d = (count_q == 12'd1) ? S_START : S_COLLECT;
            end
            S_START: begin
                if (rcnt_q == 16'(RST_CYCLES - 1)) state_d = S_RUN;
                else rcnt_d = rcnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        clr_mem_d   = (state_d == S_CLEAR);
        mem_en_d    = (state_d == S_WRITE);
        cpu_en_d    = (state_d == S_START) || (state_d == S_RUN);
        cpu_reset_d = (state_d == S_START);
        busy_d      = (state_d != S_IDLE) && (state_d != S_RUN);
        done_d      = (state_d == S_RUN) && (state_q != S_RUN);
        address_d   = mem_en_d ? addr_q : address;
        data_in_d   = mem_en_d ? word_d : data_in;
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            rcnt_q     <= '0;
            err        <= 1'b0;
            clr_mem    <= 1'b0;
            mem_en     <= 1'b0;
            read_write <= 1'b0;
            address    <= '0;
            data_in    <= '0;
            cpu_en     <= 1'b0;
            cpu_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            rcnt_q     <= rcnt_d;
            err        <= err_d;
            clr_mem    <= clr_mem_d;
            mem_en     <= mem_en_d;
            read_write <= mem_en_d;
            address    <= address_d;
            data_in    <= data_in_d;
            cpu_en     <= cpu_en_d;
            cpu_reset  <= cpu_reset_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: dut1 uses default parameters, dut2 uses
// BASE_ADDR=FFE, RST_CYCLES=2, CLEAR_FIRST=0. Expected writes go into a
// per-DUT queue as words are streamed and are popped on each write strobe.
module tb_prog_loader;
    logic main_clk = 1'b0;
    logic reset;
    always #5 main_clk = ~main_clk;

    logic start, byte_valid, byte_ready, clr_mem, mem_en, read_write;
    logic cpu_en, cpu_reset, busy, done, err;
    logic [7:0] byte_in;
    logic [11:0] address;
    logic [31:0] data_in;

    logic start2, byte_valid2, byte_ready2, clr_mem2, mem_en2, read_write2;
    logic cpu_en2, cpu_reset2, busy2, done2, err2;
    logic [7:0] byte_in2;
    logic [11:0] address2;
    logic [31:0] data_in2;

    prog_loader dut (
        .main_clk(main_clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .clr_mem(clr_mem),
        .mem_en(mem_en), .read_write(read_write), .address(address),
        .data_in(data_in), .cpu_en(cpu_en), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .err(err));

    prog_loader #(.BASE_ADDR(12'hFFE), .RST_CYCLES(2), .CLEAR_FIRST(1'b0)) dut2 (
        .main_clk(main_clk), .reset(reset), .start(start2), .byte_in(byte_in2),
        .byte_valid(byte_valid2), .byte_ready(byte_ready2), .clr_mem(clr_mem2),
        .mem_en(mem_en2), .read_write(read_write2), .address(address2),
        .data_in(data_in2), .cpu_en(cpu_en2), .cpu_reset(cpu_reset2),
        .busy(busy2), .done(done2), .err(err2));

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [11:0] a; logic [31:0] d; } wr_t;
    wr_t q1[$], q2[$];
    wr_t e1, e2;
    int wcnt1 = 0, wcnt2 = 0;
    logic [11:0] ea1, ea2;

    logic [31:0] prog [12] = '{32'h180A0000, 32'h180B0001, 32'h180F3002, 32'h500F3002,
                               32'h58FFF001, 32'h34009009, 32'h37003003, 32'h00000000,
                               32'h240020F3, 32'h90000000, 32'h00000005, 32'h00000002};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-strobe scoreboards and byte_ready quiet check.
    always @(negedge main_clk) begin
        if (!reset) begin
            if (mem_en) begin
                wcnt1++;
                if (q1.size() == 0) chk("w1_unexpected", 32'd1, 32'd0);
                else begin
                    e1 = q1.pop_front();
                    chk("w1_addr", {20'd0, address}, {20'd0, e1.a});
                    chk("w1_data", data_in, e1.d);
                    chk("w1_rw", {31'd0, read_write}, 32'd1);
                end
            end
            if (mem_en | cpu_en) chk("rdy1_quiet", {31'd0, byte_ready}, 32'd0);
            if (mem_en2) begin
                wcnt2++;
                if (q2.size() == 0) chk("w2_unexpected", 32'd1, 32'd0);
                else begin
                    e2 = q2.pop_front();
                    chk("w2_addr", {20'd0, address2}, {20'd0, e2.a});
                    chk("w2_data", data_in2, e2.d);
                end
            end
            if (mem_en2 | cpu_en2) chk("rdy2_quiet", {31'd0, byte_ready2}, 32'd0);
        end
    end

    task automatic pulse_start(input bit sel);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge main_clk);
        start = 1'b0; start2 = 1'b0;
    endtask

    // Presents a byte after 'gap' idle cycles; returns at the negedge after transfer.
    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge main_clk);
        if (sel) begin byte_in2 = b; byte_valid2 = 1'b1; end
        else begin byte_in = b; byte_valid = 1'b1; end
        while (!(sel ? byte_ready2 : byte_ready) && n < 200) begin
            @(negedge main_clk); n++;
        end
        if (n >= 200) chk("byte_accept_timeout", 32'd1, 32'd0);
        @(negedge main_clk);
        byte_valid = 1'b0; byte_valid2 = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input int gapmax);
        if (sel) begin q2.push_back({ea2, w}); ea2 = ea2 + 12'd1; end
        else begin q1.push_back({ea1, w}); ea1 = ea1 + 12'd1; end
        for (int i = 0; i < 4; i++)
            send_byte(sel, w[31-8*i -: 8], $urandom_range(0, gapmax));
    endtask

    task automatic wait_run(input bit sel, input int rc);
        int n = 0, rs = 0;
        bit got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge main_clk); n++;
            if (sel ? cpu_reset2 : cpu_reset) rs++;
            if (sel ? done2 : done) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("rst_cycles", rs, rc);
        chk("run_cpu_en", {31'd0, sel ? cpu_en2 : cpu_en}, 32'd1);
        chk("run_busy", {31'd0, sel ? busy2 : busy}, 32'd0);
        @(negedge main_clk);
        chk("done_pulse", {31'd0, sel ? done2 : done}, 32'd0);
        chk("run_cpu_reset", {31'd0, sel ? cpu_reset2 : cpu_reset}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 0; byte_valid = 0; byte_in = 0;
        start2 = 0; byte_valid2 = 0; byte_in2 = 0;
        repeat (2) @(negedge main_clk);
        // Reset state
        chk("rst_outs1", {clr_mem, mem_en, read_write, cpu_en, cpu_reset, busy, done, err, byte_ready}, 32'd0);
        chk("rst_addr", {20'd0, address}, 32'd0);
        chk("rst_data", data_in, 32'd0);
        chk("rst_outs2", {clr_mem2, mem_en2, cpu_en2, cpu_reset2, busy2, err2, byte_ready2}, 32'd0);
        reset = 1'b0;
        @(negedge main_clk);

        // Multiply program, 12 words
        pulse_start(1'b0);
        chk("clr_pulse", {31'd0, clr_mem}, 32'd1);
        chk("busy_clear", {31'd0, busy}, 32'd1);
        @(negedge main_clk);
        chk("clr_one_cycle", {31'd0, clr_mem}, 32'd0);
        ea1 = 12'h000;
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h0C, 0);
        for (int i = 0; i < 12; i++) send_word(0, prog[i], 0);
        wait_run(0, 1);
        chk("wcnt_prog", wcnt1, 12);
        chk("q_empty_prog", q1.size(), 0);

        // Restart from RUN, random gaps, start pulsed mid-COLLECT
        pulse_start(1'b0);
        chk("run_restart_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("run_restart_clr", {31'd0, clr_mem}, 32'd1);
        ea1 = 12'h000;
        send_byte(0, 8'h00, 3);
        send_byte(0, 8'h03, 5);
        send_byte(0, 8'hDE, 2);
        send_byte(0, 8'hAD, 4);
        q1.push_back({ea1, 32'hDEADBEEF}); ea1 = ea1 + 12'd1;
        pulse_start(1'b0);
        chk("start_ignored_busy", {31'd0, busy}, 32'd1);
        chk("start_ignored_clr", {31'd0, clr_mem}, 32'd0);
        send_byte(0, 8'hBE, 1);
        send_byte(0, 8'hEF, 0);
        send_word(0, 32'h01234567, 5);
        send_word(0, 32'h89ABCDEF, 5);
        wait_run(0, 1);
        chk("wcnt_gaps", wcnt1, 15);
        chk("q_empty_gaps", q1.size(), 0);

        // Zero-length header
        pulse_start(1'b0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h00, 0);
        chk("zero_err", {31'd0, err}, 32'd1);
        chk("zero_idle", {busy, cpu_en, byte_ready}, 32'd0);
        repeat (3) @(negedge main_clk);
        chk("zero_no_write", wcnt1, 15);
        chk("err_sticky", {31'd0, err}, 32'd1);
        pulse_start(1'b0);
        chk("err_cleared", {31'd0, err}, 32'd0);

        // Reset mid-word
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        reset = 1'b1;
        @(negedge main_clk);
        chk("midrst_outs", {clr_mem, mem_en, read_write, cpu_en, cpu_reset, busy, done, err, byte_ready}, 32'd0);
        chk("midrst_data", data_in, 32'd0);
        reset = 1'b0;
        @(negedge main_clk);
        chk("midrst_no_write", wcnt1, 15);
        pulse_start(1'b0);
        ea1 = 12'h000;
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h02, 0);
        send_word(0, 32'hCAFEF00D, 1);
        send_word(0, 32'h12345678, 1);
        wait_run(0, 1);
        chk("wcnt_reload", wcnt1, 17);

        // dut2: start with a simultaneous byte, address wrap, 2-cycle reset
        start2 = 1'b1; byte_valid2 = 1'b1; byte_in2 = 8'h55;
        @(negedge main_clk);
        start2 = 1'b0; byte_valid2 = 1'b0;
        chk("d2_no_clear", {31'd0, clr_mem2}, 32'd0);
        chk("d2_hdr_ready", {31'd0, byte_ready2}, 32'd1);
        ea2 = 12'hFFE;
        send_byte(1, 8'hF0, 0);   // upper nibble must be ignored
        send_byte(1, 8'h03, 0);
        send_word(1, 32'hA5A5A5A5, 2);
        send_word(1, 32'h5A5A5A5A, 2);
        send_word(1, 32'h0F0F0F0F, 2);
        wait_run(1, 2);
        chk("wcnt_d2", wcnt2, 3);
        chk("q_empty_d2", q2.size(), 0);
        chk("d2_last_addr", {20'd0, address2}, 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
